// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions: opcodes, condition codes, fetch states, flag layout.
package cpu_pkg;

    localparam int unsigned XLEN   = 16;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned CC_W   = 3;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned IMM9_W = 9;

    localparam logic [OPC_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'h1;
    localparam logic [OPC_W-1:0] OP_XOR    = 4'h2;
    localparam logic [OPC_W-1:0] OP_PADDSB = 4'h3;
    localparam logic [OPC_W-1:0] OP_SLL    = 4'h4;
    localparam logic [OPC_W-1:0] OP_SRA    = 4'h5;
    localparam logic [OPC_W-1:0] OP_ROR    = 4'h6;
    localparam logic [OPC_W-1:0] OP_RED    = 4'h7;
    localparam logic [OPC_W-1:0] OP_LW     = 4'h8;
    localparam logic [OPC_W-1:0] OP_SW     = 4'h9;
    localparam logic [OPC_W-1:0] OP_LHB    = 4'hA;
    localparam logic [OPC_W-1:0] OP_LLB    = 4'hB;
    localparam logic [OPC_W-1:0] OP_B      = 4'hC;
    localparam logic [OPC_W-1:0] OP_BR     = 4'hD;
    localparam logic [OPC_W-1:0] OP_PCS    = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT    = 4'hF;

    localparam logic [CC_W-1:0] CC_NE   = 3'b000;
    localparam logic [CC_W-1:0] CC_EQ   = 3'b001;
    localparam logic [CC_W-1:0] CC_GT   = 3'b010;
    localparam logic [CC_W-1:0] CC_LT   = 3'b011;
    localparam logic [CC_W-1:0] CC_GTE  = 3'b100;
    localparam logic [CC_W-1:0] CC_LTE  = 3'b101;
    localparam logic [CC_W-1:0] CC_OVFL = 3'b110;
    localparam logic [CC_W-1:0] CC_UNC  = 3'b111;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

    // Flag register layout, MSB first: {N, Z, V}
    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    // Sign-extended 9-bit word offset, scaled to bytes
    function automatic logic [XLEN-1:0] branch_disp(input logic [IMM9_W-1:0] imm);
        return {{(XLEN-IMM9_W-1){imm[IMM9_W-1]}}, imm, 1'b0};
    endfunction

    function automatic logic writes_nzv(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic writes_z_only(input logic [OPC_W-1:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge handshake.
interface imem_if
    import cpu_pkg::*;
();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/pc_fetch_unit_branch_cond.sv
// Evaluates a 3-bit branch condition against the {N,Z,V} flag register.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [CC_W-1:0]   ccc,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken
);

    // Condition decode
    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:   taken = !flags[FLAG_Z];
            CC_EQ:   taken =  flags[FLAG_Z];
            CC_GT:   taken = !flags[FLAG_Z] && !flags[FLAG_N];
            CC_LT:   taken =  flags[FLAG_N];
            CC_GTE:  taken =  flags[FLAG_Z] || !flags[FLAG_N];
            CC_LTE:  taken =  flags[FLAG_N] ||  flags[FLAG_Z];
            CC_OVFL: taken =  flags[FLAG_V];
            CC_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction fetcher: fetches over imem, presents the instruction
// until retirement, owns the flag register and resolves next-PC selection.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_if.master            imem,
    output logic [XLEN-1:0]   instr,
    output logic              instr_valid,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus2,
    input  logic              exec_stall,
    input  logic [XLEN-1:0]   rs_data,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    output logic [FLAG_W-1:0] flags,
    output logic              halted
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus2_q, pc_plus2_d;
    logic [XLEN-1:0] instr_q, instr_d;
    flags_t          flags_q, flags_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;

    logic [OPC_W-1:0] opcode;
    logic             cond_taken;
    logic [XLEN-1:0]  pc_seq;
    logic [XLEN-1:0]  pc_next;
    flags_t           flags_next;

    assign opcode = instr_q[15:12];

    branch_cond u_branch_cond (
        .ccc   (instr_q[11:9]),
        .flags (flags_q),
        .taken (cond_taken)
    );

    // Next-PC selection for the instruction in EXEC
    always_comb begin
        pc_seq  = pc_q + 16'd2;
        pc_next = pc_seq;
        case (opcode)
            OP_B:    if (cond_taken) pc_next = pc_seq + branch_disp(instr_q[8:0]);
            OP_BR:   if (cond_taken) pc_next = rs_data & 16'hFFFE;
            OP_HLT:  pc_next = pc_q;
            default: pc_next = pc_seq;
        endcase
    end

    // Flag update value applied at the retire edge
    always_comb begin
        flags_next = flags_q;
        if (writes_nzv(opcode)) begin
            flags_next = '{n: alu_n, z: alu_z, v: alu_v};
        end else if (writes_z_only(opcode)) begin
            flags_next.z = alu_z;
        end
    end

    // Fetch/execute/halt sequencing and next-state for all registers
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        flags_d  = flags_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        unique case (state_q)
            S_FETCH: begin
                req_d = 1'b1;
                if (req_q && imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_EXEC;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (!exec_stall) begin
                    flags_d = flags_next;
                    valid_d = 1'b0;
                    if (opcode == OP_HLT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        req_d    = 1'b0;
                    end else begin
                        pc_d    = pc_next;
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                    end
                end
            end
            S_HALT: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        pc_plus2_d = pc_d + 16'd2;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pc_plus2_q <= RESET_PC + 16'd2;
            instr_q    <= '0;
            flags_q    <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus2_q <= pc_plus2_d;
            instr_q    <= instr_d;
            flags_q    <= flags_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign pc_plus2       = pc_plus2_q;
    assign flags          = flags_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against an architectural model of fetch/retire.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr, pc, pc_plus2, rs_data;
    logic        instr_valid, exec_stall, alu_n, alu_z, alu_v, halted;
    logic [2:0]  flags;

    imem_if bus ();

    pc_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .exec_stall  (exec_stall),
        .rs_data     (rs_data),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_v       (alu_v),
        .flags       (flags),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instruction memory image, populated with random words on first touch
    logic [15:0] mem [logic [15:0]];
    logic [15:0] fetch_log [$];
    int          lat_min = 0, lat_max = 0;
    bit          glitch_en = 1'b1;

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 31) != 0) w[15:12] = 4'hE;
        return w;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = rand_instr();
        return mem[a];
    endfunction

    task automatic chk(input bit ok, input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: random latency per fetch; stray acks only when clearly not fetching
    initial begin
        int cnt;
        cnt = 0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 16'($urandom);
            if (!rst_n) begin
                cnt = $urandom_range(lat_min, lat_max);
            end else if (bus.imem_req) begin
                if (cnt == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_rd(bus.imem_addr);
                    fetch_log.push_back(bus.imem_addr);
                    cnt = $urandom_range(lat_min, lat_max);
                end else begin
                    cnt--;
                end
            end else if (glitch_en && (instr_valid || halted) && $urandom_range(0, 5) == 0) begin
                bus.imem_ack = 1'b1;
            end
        end
    end

    // Architectural model state
    logic [15:0] exp_pc;
    logic [2:0]  exp_flags;
    bit          exp_halted, post_rst, just_ret;

    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit n, z, v;
        {n, z, v} = f;
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_retire();
        logic [15:0] iw;
        logic [3:0]  op;
        int          off;
        bit          tk;
        iw  = mem_rd(exp_pc);
        op  = iw[15:12];
        tk  = cond_ok(iw[11:9], exp_flags);
        off = int'(iw[8:0]);
        if (iw[8]) off -= 512;
        if (op == 4'hF) begin
            exp_halted = 1'b1;
        end else if (op == 4'hC && tk) begin
            exp_pc = 16'(int'(exp_pc) + 2 + 2 * off);
        end else if (op == 4'hD && tk) begin
            exp_pc = rs_data & 16'hFFFE;
        end else begin
            exp_pc = 16'(exp_pc + 16'd2);
        end
        if (op == 4'h0 || op == 4'h1) exp_flags = {alu_n, alu_z, alu_v};
        else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) exp_flags[1] = alu_z;
    endtask

    // Per-cycle compare against the model, away from the rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk(pc == 16'h0000, "rst_pc", pc, 16'h0000);
            chk(instr == 16'h0000, "rst_instr", instr, 16'h0000);
            chk(flags == 3'b000, "rst_flags", 16'(flags), 16'h0);
            chk({bus.imem_req, instr_valid, halted} == 3'b000, "rst_ctrl",
                16'({bus.imem_req, instr_valid, halted}), 16'h0);
            exp_pc = 16'h0000; exp_flags = 3'b000; exp_halted = 1'b0;
            post_rst = 1'b1; just_ret = 1'b0;
        end else if (post_rst) begin
            chk({bus.imem_req, instr_valid, halted} == 3'b000, "post_rst_ctrl",
                16'({bus.imem_req, instr_valid, halted}), 16'h0);
            post_rst = 1'b0;
        end else begin
            chk(halted == exp_halted, "halted", 16'(halted), 16'(exp_halted));
            chk(flags == exp_flags, "flags", 16'(flags), 16'(exp_flags));
            chk(pc == exp_pc, "pc", pc, exp_pc);
            if (exp_halted) begin
                chk({bus.imem_req, instr_valid} == 2'b00, "halt_idle",
                    16'({bus.imem_req, instr_valid}), 16'h0);
            end else begin
                chk(bus.imem_req ^ instr_valid, "req_xor_valid",
                    16'({bus.imem_req, instr_valid}), 16'h1);
                if (just_ret) chk(!instr_valid, "min_2_cycles", 16'(instr_valid), 16'h0);
                if (bus.imem_req) chk(bus.imem_addr == exp_pc, "imem_addr", bus.imem_addr, exp_pc);
                if (instr_valid) begin
                    chk(instr == mem_rd(exp_pc), "instr", instr, mem_rd(exp_pc));
                    chk(pc_plus2 == 16'(exp_pc + 16'd2), "pc_plus2", pc_plus2, 16'(exp_pc + 16'd2));
                end
            end
            just_ret = 1'b0;
            if (instr_valid && !exec_stall && !exp_halted) begin
                model_retire();
                just_ret = 1'b1;
            end
        end
    end

    task automatic begin_test(input int lmin, input int lmax);
        rst_n = 1'b0;
        mem.delete();
        fetch_log.delete();
        lat_min = lmin;
        lat_max = lmax;
        exec_stall = 1'b0;
        {alu_n, alu_z, alu_v} = 3'b000;
        rs_data = 16'h0000;
    endtask

    task automatic end_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 80 && !halted; i++) cyc();
        chk(halted, name, 16'(halted), 16'h1);
        cyc();
    endtask

    task automatic wait_exec_at(input logic [15:0] a, input string name);
        for (int i = 0; i < 80 && !(instr_valid && pc == a); i++) cyc();
        chk(instr_valid && pc == a, name, pc, a);
    endtask

    task automatic wait_retire(input string name);
        for (int i = 0; i < 20 && instr_valid; i++) cyc();
        chk(!instr_valid, name, 16'(instr_valid), 16'h0);
    endtask

    initial begin
        logic [15:0] q0, q1, q2;
        int nreq, hcnt;
        exec_stall = 1'b0; rs_data = 16'h0; {alu_n, alu_z, alu_v} = 3'b000;

        // ADD, SUB, HLT with zero-wait memory
        begin_test(0, 0);
        mem[16'h0000] = 16'h0000; mem[16'h0002] = 16'h1000; mem[16'h0004] = 16'hF000;
        end_reset();
        wait_halt("t1_halt");
        chk(pc == 16'h0004, "t1_pc", pc, 16'h0004);
        chk(!bus.imem_req, "t1_req_low", 16'(bus.imem_req), 16'h0);
        chk(fetch_log.size() == 3, "t1_nfetch", 16'(fetch_log.size()), 16'd3);
        if (fetch_log.size() == 3) begin
            q0 = fetch_log[0]; q1 = fetch_log[1]; q2 = fetch_log[2];
            chk({q0, q1, q2} == {16'h0, 16'h2, 16'h4}, "t1_addr_seq", q2, 16'h4);
        end
        repeat (3) cyc();
        chk(halted && pc == 16'h0004, "t1_stays_halted", pc, 16'h0004);

        // ADD sets Z, B EQ backwards from 0x0010
        begin_test(0, 2);
        mem[16'h0000] = 16'hCE06; mem[16'h000E] = 16'h0000; mem[16'h0010] = 16'hC3FE;
        alu_z = 1'b1;
        end_reset();
        wait_exec_at(16'h0010, "t2_at_b");
        wait_retire("t2_b_retire");
        chk(flags == 3'b010, "t2_flags", 16'(flags), 16'h2);
        chk(bus.imem_req && bus.imem_addr == 16'h000E, "t2_target", bus.imem_addr, 16'h000E);

        // XOR writes only Z; B LT not taken
        begin_test(1, 1);
        mem[16'h0000] = 16'h2000; mem[16'h0002] = 16'hC605; mem[16'h0004] = 16'hF000;
        {alu_n, alu_z, alu_v} = 3'b111;
        end_reset();
        wait_halt("t3_halt");
        chk(pc == 16'h0004, "t3_not_taken_pc", pc, 16'h0004);
        chk(flags == 3'b010, "t3_flags_z_only", 16'(flags), 16'h2);

        // PCS writeback value and BR with bit 0 cleared
        begin_test(0, 1);
        mem[16'h0000] = 16'hCE0F; mem[16'h0020] = 16'hE000; mem[16'h0022] = 16'hDE00;
        mem[16'h1234] = 16'hF000;
        rs_data = 16'h1235;
        end_reset();
        wait_exec_at(16'h0020, "t4_at_pcs");
        chk(pc_plus2 == 16'h0022, "t4_pc_plus2", pc_plus2, 16'h0022);
        wait_halt("t4_halt");
        chk(pc == 16'h1234, "t4_br_target", pc, 16'h1234);

        // Delayed ack and a 3-cycle stall with toggling alu_z
        begin_test(4, 4);
        mem[16'h0000] = 16'h0000; mem[16'h0002] = 16'hF000;
        exec_stall = 1'b1;
        end_reset();
        nreq = 0;
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            if (bus.imem_req) nreq++;
            cyc();
        end
        chk(nreq == 5, "t5_req_held", 16'(nreq), 16'd5);
        for (int k = 0; k < 3; k++) begin
            chk(instr_valid && pc == 16'h0000, "t5_stall_hold", pc, 16'h0000);
            alu_z = ~alu_z;
            cyc();
        end
        chk(instr_valid && flags == 3'b000, "t5_no_flag_in_stall", 16'(flags), 16'h0);
        exec_stall = 1'b0; {alu_n, alu_z, alu_v} = 3'b101;
        cyc();
        chk(flags == 3'b101, "t5_retire_flags", 16'(flags), 16'h5);
        wait_halt("t5_halt");

        // Reset during EXEC of a taken branch
        begin_test(0, 0);
        mem[16'h0000] = 16'hCE14;
        exec_stall = 1'b1;
        end_reset();
        wait_exec_at(16'h0000, "t6_at_b");
        cyc();
        rst_n = 1'b0;
        cyc();
        chk(pc == 16'h0000 && flags == 3'b000 && !instr_valid, "t6_reset_mid_exec", pc, 16'h0000);
        rst_n = 1'b1;
        exec_stall = 1'b0;
        for (int i = 0; i < 5 && !bus.imem_req; i++) cyc();
        chk(bus.imem_req && bus.imem_addr == 16'h0000, "t6_refetch", bus.imem_addr, 16'h0000);

        // PC wrap from 0xFFFE
        begin_test(0, 1);
        mem[16'h0000] = 16'hDE00; mem[16'hFFFE] = 16'h0000;
        rs_data = 16'hFFFF;
        end_reset();
        wait_exec_at(16'hFFFE, "t7_at_fffe");
        wait_retire("t7_retire");
        chk(bus.imem_req && bus.imem_addr == 16'h0000, "t7_wrap", bus.imem_addr, 16'h0000);

        // Randomized traffic
        begin_test(0, 3);
        end_reset();
        hcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            exec_stall = ($urandom_range(0, 3) == 0);
            {alu_n, alu_z, alu_v} = 3'($urandom);
            rs_data = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if (halted) hcnt++;
            if (hcnt > 3 || $urandom_range(0, 699) == 0) begin
                hcnt = 0;
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
